// File: rtl/fp64_atan2.sv
// fp64_atan2: binary64 atan2(y, x) using a 64-bit fixed-point CORDIC in vectoring mode.
// The core performs one CORDIC iteration per clock and holds each result until it is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   an operand pair is offered on y/x
//   in_ready   the block accepts operands (IDLE only)
//   y, x       binary64 ordinate / abscissa
//   out_valid  angle/invalid/inexact hold a result
//   out_ready  the consumer takes the result
//   angle      binary64 atan2(y, x) in radians, range [-pi, +pi]
//   invalid    a signalling-NaN operand produced the result
//   inexact    the result is rounded (every non-NaN result except exact zeros)
//
// Latency: ITER+2 cycles from accept to out_valid for finite nonzero operands, and
// 2 cycles for special operands, which skip the ITER state. ITER must be in 2..64.
module fp64_atan2 #(
    parameter int unsigned ITER = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] y,
    input  logic [63:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] angle,
    output logic        invalid,
    output logic        inexact
);

    localparam int unsigned W       = 64;
    localparam int unsigned CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned ROM_N   = 1 << CNT_W;
    // Mantissas sit at 2^60 scale so CORDIC gain * sqrt(2) * 2 still fits below the sign bit.
    localparam int unsigned MANT_SH = 7;
    // pi with 61 fraction bits
    localparam logic [W-1:0] PI_FX  = 64'h6487_ED51_10B4_611A;
    localparam logic [62:0] PI_MAG   = 63'h4009_21FB_5444_2D18;
    localparam logic [62:0] PI2_MAG  = 63'h3FF9_21FB_5444_2D18;
    localparam logic [62:0] PI4_MAG  = 63'h3FE9_21FB_5444_2D18;
    localparam logic [62:0] PI34_MAG = 63'h4002_D97C_7F33_21D2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_NORM,
        S_DONE
    } state_t;

    // atan(2^-i) with 61 fraction bits, rounded to nearest. Euler's series
    // atan(t) = t/(1+t^2) * sum_n prod_{k<=n} (2k/(2k+1)) * (t^2/(1+t^2))^n,
    // evaluated with 124 fraction bits; it converges at least as fast as 2^-n.
    function automatic logic [W-1:0] atan_fx(input int unsigned i);
        logic [135:0] den;
        logic [135:0] term;
        logic [135:0] sum;
        den  = (136'(1) << (2 * i)) + 136'(1);
        term = ((136'(1) << 124) / den) << i;
        sum  = term;
        for (int n = 1; n <= 110; n++) begin
            term = (term * 136'(2 * n)) / (136'(2 * n + 1) * den);
            sum  = sum + term;
        end
        return W'((sum + (136'(1) << 62)) >> 63);
    endfunction

    logic [W-1:0] atan_rom [ROM_N];
    for (genvar g = 0; g < ROM_N; g++) begin : g_rom
        localparam logic [W-1:0] ENTRY = atan_fx(g);
        assign atan_rom[g] = ENTRY;
    end

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [63:0]           y_op_q, y_op_d, x_op_q, x_op_d;
    logic signed [W-1:0]   xr_q, xr_d, yr_q, yr_d, z_q, z_d;
    logic                  x_neg_q, x_neg_d, y_neg_q, y_neg_d;
    logic                  special_q, special_d;
    logic [63:0]           spec_angle_q, spec_angle_d;
    logic                  spec_inv_q, spec_inv_d, spec_inx_q, spec_inx_d;
    logic [63:0]           angle_q, angle_d;
    logic                  invalid_q, invalid_d, inexact_q, inexact_d;
    logic                  out_valid_q, out_valid_d, in_ready_q, in_ready_d;

    // Operand classification and alignment (valid while in PREP)
    logic [10:0]  ey, ex, emax, dy, dx;
    logic         y_nan, x_nan, y_inf, x_inf, y_zero, x_zero;
    logic         cls_special, cls_inv, cls_inx;
    logic [63:0]  cls_angle;
    logic [W-1:0] y_fix, x_fix;

    always_comb begin : classify
        ey     = y_op_q[62:52];
        ex     = x_op_q[62:52];
        y_nan  = (ey == 11'h7FF) && (y_op_q[51:0] != 52'd0);
        x_nan  = (ex == 11'h7FF) && (x_op_q[51:0] != 52'd0);
        y_inf  = (ey == 11'h7FF) && (y_op_q[51:0] == 52'd0);
        x_inf  = (ex == 11'h7FF) && (x_op_q[51:0] == 52'd0);
        y_zero = (ey == 11'd0);   // denormals count as signed zero
        x_zero = (ex == 11'd0);

        cls_special = 1'b1;
        cls_inv     = 1'b0;
        cls_inx     = 1'b1;
        cls_angle   = '0;
        if (y_nan) begin
            cls_angle = y_op_q | (64'd1 << 51);
            cls_inv   = ~y_op_q[51];
            cls_inx   = 1'b0;
        end else if (x_nan) begin
            cls_angle = x_op_q | (64'd1 << 51);
            cls_inv   = ~x_op_q[51];
            cls_inx   = 1'b0;
        end else if (y_zero) begin
            cls_angle = x_op_q[63] ? {y_op_q[63], PI_MAG} : {y_op_q[63], 63'd0};
            cls_inx   = x_op_q[63];
        end else if (x_zero) begin
            cls_angle = {y_op_q[63], PI2_MAG};
        end else if (y_inf && x_inf) begin
            cls_angle = x_op_q[63] ? {y_op_q[63], PI34_MAG} : {y_op_q[63], PI4_MAG};
        end else if (y_inf) begin
            cls_angle = {y_op_q[63], PI2_MAG};
        end else if (x_inf) begin
            cls_angle = x_op_q[63] ? {y_op_q[63], PI_MAG} : {y_op_q[63], 63'd0};
            cls_inx   = x_op_q[63];
        end else begin
            cls_special = 1'b0;
        end

        // Align the smaller-exponent magnitude to the larger exponent
        emax  = (ey > ex) ? ey : ex;
        dy    = emax - ey;
        dx    = emax - ex;
        y_fix = (dy >= 11'd64) ? '0 : ((W'({1'b1, y_op_q[51:0]}) << MANT_SH) >> dy[5:0]);
        x_fix = (dx >= 11'd64) ? '0 : ((W'({1'b1, x_op_q[51:0]}) << MANT_SH) >> dx[5:0]);
    end

    // One CORDIC vectoring micro-rotation, driving y towards zero
    logic signed [W-1:0] it_xs, it_ys, it_x, it_y, it_z, it_atan;

    always_comb begin : cordic_step
        it_xs   = xr_q >>> cnt_q;
        it_ys   = yr_q >>> cnt_q;
        it_atan = $signed(atan_rom[cnt_q]);
        if (yr_q[W-1]) begin
            it_x = xr_q - it_ys;
            it_y = yr_q + it_xs;
            it_z = z_q - it_atan;
        end else begin
            it_x = xr_q + it_ys;
            it_y = yr_q - it_xs;
            it_z = z_q + it_atan;
        end
    end

    // Quadrant fold, normalise and pack the first-quadrant angle
    logic [W-1:0] norm_mag;
    logic [5:0]   norm_msb;
    logic [63:0]  norm_angle;

    always_comb begin : normalise
        // A tiny residual below zero is clamped; the true angle is >= 0 here.
        norm_mag = z_q[W-1] ? '0 : $unsigned(z_q);
        if (x_neg_q) begin
            norm_mag = PI_FX - norm_mag;
        end
        norm_msb = '0;
        for (int k = 0; k < 64; k++) begin
            if (norm_mag[k]) begin
                norm_msb = 6'(k);
            end
        end
        if (norm_mag == '0) begin
            norm_angle = {y_neg_q, 63'd0};
        end else begin
            norm_angle = {y_neg_q, 11'(norm_msb) + 11'd962,
                          52'((norm_mag << (6'd63 - norm_msb)) >> 11)};
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            y_op_q       <= '0;
            x_op_q       <= '0;
            xr_q         <= '0;
            yr_q         <= '0;
            z_q          <= '0;
            x_neg_q      <= 1'b0;
            y_neg_q      <= 1'b0;
            special_q    <= 1'b0;
            spec_angle_q <= '0;
            spec_inv_q   <= 1'b0;
            spec_inx_q   <= 1'b0;
            angle_q      <= '0;
            invalid_q    <= 1'b0;
            inexact_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            y_op_q       <= y_op_d;
            x_op_q       <= x_op_d;
            xr_q         <= xr_d;
            yr_q         <= yr_d;
            z_q          <= z_d;
            x_neg_q      <= x_neg_d;
            y_neg_q      <= y_neg_d;
            special_q    <= special_d;
            spec_angle_q <= spec_angle_d;
            spec_inv_q   <= spec_inv_d;
            spec_inx_q   <= spec_inx_d;
            angle_q      <= angle_d;
            invalid_q    <= invalid_d;
            inexact_q    <= inexact_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        cnt_d        = cnt_q;
        y_op_d       = y_op_q;
        x_op_d       = x_op_q;
        xr_d         = xr_q;
        yr_d         = yr_q;
        z_d          = z_q;
        x_neg_d      = x_neg_q;
        y_neg_d      = y_neg_q;
        special_d    = special_q;
        spec_angle_d = spec_angle_q;
        spec_inv_d   = spec_inv_q;
        spec_inx_d   = spec_inx_q;
        angle_d      = angle_q;
        invalid_d    = invalid_q;
        inexact_d    = inexact_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    y_op_d  = y;
                    x_op_d  = x;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                special_d    = cls_special;
                spec_angle_d = cls_angle;
                spec_inv_d   = cls_inv;
                spec_inx_d   = cls_inx;
                x_neg_d      = x_op_q[63];
                y_neg_d      = y_op_q[63];
                xr_d         = $signed(x_fix);
                yr_d         = $signed(y_fix);
                z_d          = '0;
                cnt_d        = '0;
                state_d      = cls_special ? S_NORM : S_ITER;
            end
            S_ITER: begin
                xr_d = it_x;
                yr_d = it_y;
                z_d  = it_z;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    cnt_d   = '0;
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_NORM: begin
                if (special_q) begin
                    angle_d   = spec_angle_q;
                    invalid_d = spec_inv_q;
                    inexact_d = spec_inx_q;
                end else begin
                    angle_d   = norm_angle;
                    invalid_d = 1'b0;
                    inexact_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign angle     = angle_q;
    assign invalid   = invalid_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp64_atan2.sv
// Directed self-checking bench for fp64_atan2 with hand-computed expected values.
module tb_fp64_atan2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] y;
    logic [63:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] angle;
    logic        invalid;
    logic        inexact;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp64_atan2 #(.ITER(60)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .x        (x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .angle    (angle),
        .invalid  (invalid),
        .inexact  (inexact)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ulp(input string tag, input logic [63:0] obs, input logic [63:0] exp,
                           input int tol);
        longint diff;
        diff = longint'(obs) - longint'(exp);
        if (diff < 0) diff = -diff;
        checks++;
        assert (!$isunknown(obs) && diff <= longint'(tol)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (+/-%0d ulp)", tag, obs, exp, tol);
        end
    endtask

    // Offer one operand pair; returns just after the accept edge with junk on the inputs.
    task automatic start_op(input logic [63:0] yv, input logic [63:0] xv);
        @(negedge clk);
        y        = yv;
        x        = xv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        y        = 64'hDEAD_BEEF_0BAD_F00D;
        x        = 64'hFFF0_0000_0000_0001;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Take the result with a one-cycle out_ready pulse while a new pair is offered.
    task automatic handoff(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, ".ovalid_after"}, 64'(out_valid), 64'd0);
        chk({tag, ".iready_after"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run(input string tag, input logic [63:0] yv, input logic [63:0] xv,
                       input int exp_lat, input logic [63:0] exp_a, input int tol,
                       input logic exp_inv, input logic exp_inx);
        int lat;
        start_op(yv, xv);
        wait_valid(lat);
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        if (tol == 0) chk({tag, ".angle"}, angle, exp_a);
        else          chk_ulp({tag, ".angle"}, angle, exp_a, tol);
        chk({tag, ".invalid"}, 64'(invalid), 64'(exp_inv));
        chk({tag, ".inexact"}, 64'(inexact), 64'(exp_inx));
        handoff(tag);
    endtask

    initial begin
        int lat;
        logic [63:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y         = '0;
        x         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.angle", angle, 64'd0);
        chk("rst.flags", 64'({invalid, inexact}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        // Finite nonzero operands through the CORDIC path
        run("pi_4",   64'h3FF0000000000000, 64'h3FF0000000000000, 62, 64'h3FE921FB54442D18, 4, 1'b0, 1'b1);
        run("3pi_4",  64'h3FF0000000000000, 64'hBFF0000000000000, 62, 64'h4002D97C7F3321D2, 4, 1'b0, 1'b1);
        run("m3pi_4", 64'hBFF0000000000000, 64'hBFF0000000000000, 62, 64'hC002D97C7F3321D2, 4, 1'b0, 1'b1);

        // Special operands
        run("mzero_m2", 64'h8000000000000000, 64'hC000000000000000, 2, 64'hC00921FB54442D18, 0, 1'b0, 1'b1);
        run("zero_zero", 64'h0000000000000000, 64'h0000000000000000, 2, 64'h0000000000000000, 0, 1'b0, 1'b0);
        run("snan_y", 64'h7FF0000000000001, 64'h3FF0000000000000, 2, 64'h7FF8000000000001, 0, 1'b1, 1'b0);
        run("qnan_x", 64'h3FF0000000000000, 64'hFFF8000000000005, 2, 64'hFFF8000000000005, 0, 1'b0, 1'b0);
        run("y_first", 64'h7FF8000000000000, 64'h7FF0000000000001, 2, 64'h7FF8000000000000, 0, 1'b0, 1'b0);
        run("inf_minf", 64'h7FF0000000000000, 64'hFFF0000000000000, 2, 64'h4002D97C7F3321D2, 0, 1'b0, 1'b1);
        run("minf_inf", 64'hFFF0000000000000, 64'h7FF0000000000000, 2, 64'hBFE921FB54442D18, 0, 1'b0, 1'b1);
        run("m5_zero",  64'hC014000000000000, 64'h0000000000000000, 2, 64'hBFF921FB54442D18, 0, 1'b0, 1'b1);
        run("one_inf",  64'h3FF0000000000000, 64'h7FF0000000000000, 2, 64'h0000000000000000, 0, 1'b0, 1'b0);
        run("m1_minf",  64'hBFF0000000000000, 64'hFFF0000000000000, 2, 64'hC00921FB54442D18, 0, 1'b0, 1'b1);
        run("denorm_m1", 64'h0000000000000001, 64'hBFF0000000000000, 2, 64'h400921FB54442D18, 0, 1'b0, 1'b1);

        // Result held while the consumer stalls; new operands are ignored meanwhile
        start_op(64'hBFF0000000000000, 64'h3FF0000000000000);
        wait_valid(lat);
        chk("hold.latency", 64'(lat), 64'd62);
        chk_ulp("hold.angle", angle, 64'hBFE921FB54442D18, 4);
        held     = angle;
        in_valid = 1'b1;
        y        = 64'h4000000000000000;
        x        = 64'h4000000000000000;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("hold.stable", angle, held);
            chk("hold.ctl", 64'({out_valid, in_ready, invalid, inexact}), 64'b1001);
        end
        in_valid = 1'b0;
        handoff("hold");

        // Reset in the middle of ITER, with in_valid also high, then a fresh operation
        start_op(64'h4000000000000000, 64'h3FF0000000000000);
        repeat (31) @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.in_ready", 64'(in_ready), 64'd1);
        chk("abort.angle", angle, 64'd0);
        run("pi_6", 64'h3FF0000000000000, 64'h3FFBB67AE8584CAA, 62, 64'h3FE0C152382D7365, 4, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
